// File: rtl/wheel_update_sequencer.sv
// Runs the rpm and rad/s conversion for every wheel through one shared multiplier,
// then commits the whole result set in a single cycle.
module wheel_update_sequencer #(
    parameter int unsigned        N_WIDTH   = 17,
    parameter int unsigned        RPM_DATA  = 8,
    parameter int unsigned        WHEELS    = 4,
    parameter int unsigned        TIMEOUT   = 64,
    parameter logic [N_WIDTH-1:0] K_PUL2RPM = 17'h004C5,
    parameter logic [N_WIDTH-1:0] K_RPM2RAD = 17'h0001B
) (
    input  logic                        WHEEL_UPDATE_SEQUENCER_CLOCK,
    input  logic                        WHEEL_UPDATE_SEQUENCER_RESET_InLow,
    input  logic                        WHEEL_UPDATE_SEQUENCER_TICK_In,
    input  logic [WHEELS*RPM_DATA-1:0]  WHEEL_UPDATE_SEQUENCER_COUNT_InBus,
    output logic                        WHEEL_UPDATE_SEQUENCER_MULREQ_Out,
    output logic [N_WIDTH-1:0]          WHEEL_UPDATE_SEQUENCER_MULA_OutBus,
    output logic [N_WIDTH-1:0]          WHEEL_UPDATE_SEQUENCER_MULB_OutBus,
    input  logic                        WHEEL_UPDATE_SEQUENCER_MULACK_In,
    input  logic [N_WIDTH-1:0]          WHEEL_UPDATE_SEQUENCER_MULRESULT_InBus,
    output logic [WHEELS*N_WIDTH-1:0]   WHEEL_UPDATE_SEQUENCER_RPM_OutBus,
    output logic [WHEELS*N_WIDTH-1:0]   WHEEL_UPDATE_SEQUENCER_RAD_OutBus,
    output logic                        WHEEL_UPDATE_SEQUENCER_BUSY_Out,
    output logic                        WHEEL_UPDATE_SEQUENCER_DONE_Out,
    output logic                        WHEEL_UPDATE_SEQUENCER_OVERRUN_Out,
    output logic                        WHEEL_UPDATE_SEQUENCER_TIMEOUT_Out
);
    localparam int unsigned WH_W  = (WHEELS > 1) ? $clog2(WHEELS) : 1;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned CNT_W = WHEELS * RPM_DATA;
    localparam int unsigned BUS_W = WHEELS * N_WIDTH;

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t             state_q, state_d;
    logic [WH_W-1:0]    wheel_q, wheel_d;
    logic               rad_op_q, rad_op_d;
    logic [TO_W-1:0]    wait_q, wait_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BUS_W-1:0]   rpm_sh_q, rpm_sh_d, rad_sh_q, rad_sh_d;
    logic [BUS_W-1:0]   rpm_out_q, rad_out_q;
    logic [N_WIDTH-1:0] mula_q, mula_d, mulb_q, mulb_d, slot_val;
    logic               mulreq_q, busy_q, done_q;
    logic               overrun_q, overrun_d, timeout_q, timeout_d;
    logic               last_op;

    assign last_op = rad_op_q && (wheel_q == WH_W'(WHEELS - 1));

    // Next-state, op sequencing and shadow capture
    always_comb begin
        state_d   = state_q;
        wheel_d   = wheel_q;
        rad_op_d  = rad_op_q;
        wait_d    = wait_q;
        cnt_d     = cnt_q;
        rpm_sh_d  = rpm_sh_q;
        rad_sh_d  = rad_sh_q;
        overrun_d = overrun_q;
        timeout_d = timeout_q;
        slot_val  = WHEEL_UPDATE_SEQUENCER_MULACK_In ? WHEEL_UPDATE_SEQUENCER_MULRESULT_InBus
                                                     : '0;
        unique case (state_q)
            IDLE: begin
                if (WHEEL_UPDATE_SEQUENCER_TICK_In) begin
                    cnt_d    = WHEEL_UPDATE_SEQUENCER_COUNT_InBus;
                    wheel_d  = '0;
                    rad_op_d = 1'b0;
                    wait_d   = '0;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (WHEEL_UPDATE_SEQUENCER_MULACK_In || (wait_q == TO_W'(TIMEOUT - 1))) begin
                    if (!WHEEL_UPDATE_SEQUENCER_MULACK_In) begin
                        timeout_d = 1'b1;
                    end
                    for (int unsigned w = 0; w < WHEELS; w++) begin
                        if (wheel_q == WH_W'(w)) begin
                            if (rad_op_q) begin
                                rad_sh_d[w*N_WIDTH +: N_WIDTH] = slot_val;
                            end else begin
                                rpm_sh_d[w*N_WIDTH +: N_WIDTH] = slot_val;
                            end
                        end
                    end
                    wait_d  = '0;
                    state_d = last_op ? DONE : GAP;
                end else begin
                    wait_d = wait_q + TO_W'(1);
                end
            end
            GAP: begin
                if (rad_op_q) begin
                    wheel_d = wheel_q + WH_W'(1);
                end
                rad_op_d = ~rad_op_q;
                state_d  = REQ;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (WHEEL_UPDATE_SEQUENCER_TICK_In && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end
    end

    // Operands for the op about to be requested
    always_comb begin
        mula_d = mula_q;
        mulb_d = mulb_q;
        if (state_d == REQ) begin
            for (int unsigned w = 0; w < WHEELS; w++) begin
                if (wheel_d == WH_W'(w)) begin
                    if (rad_op_d) begin
                        mula_d = rpm_sh_d[w*N_WIDTH +: N_WIDTH];
                        mulb_d = K_RPM2RAD;
                    end else begin
                        mula_d = N_WIDTH'({cnt_d[w*RPM_DATA +: RPM_DATA], 8'h00});
                        mulb_d = K_PUL2RPM;
                    end
                end
            end
        end
    end

    always_ff @(posedge WHEEL_UPDATE_SEQUENCER_CLOCK) begin
        if (!WHEEL_UPDATE_SEQUENCER_RESET_InLow) begin
            state_q   <= IDLE;
            wheel_q   <= '0;
            rad_op_q  <= 1'b0;
            wait_q    <= '0;
            cnt_q     <= '0;
            rpm_sh_q  <= '0;
            rad_sh_q  <= '0;
            rpm_out_q <= '0;
            rad_out_q <= '0;
            mula_q    <= '0;
            mulb_q    <= '0;
            mulreq_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            overrun_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wheel_q   <= wheel_d;
            rad_op_q  <= rad_op_d;
            wait_q    <= wait_d;
            cnt_q     <= cnt_d;
            rpm_sh_q  <= rpm_sh_d;
            rad_sh_q  <= rad_sh_d;
            mula_q    <= mula_d;
            mulb_q    <= mulb_d;
            mulreq_q  <= (state_d == REQ);
            busy_q    <= (state_d != IDLE);
            done_q    <= (state_d == DONE);
            overrun_q <= overrun_d;
            timeout_q <= timeout_d;
            // Commit includes the final result captured on this same edge
            if (state_d == DONE) begin
                rpm_out_q <= rpm_sh_d;
                rad_out_q <= rad_sh_d;
            end
        end
    end

    assign WHEEL_UPDATE_SEQUENCER_MULREQ_Out  = mulreq_q;
    assign WHEEL_UPDATE_SEQUENCER_MULA_OutBus = mula_q;
    assign WHEEL_UPDATE_SEQUENCER_MULB_OutBus = mulb_q;
    assign WHEEL_UPDATE_SEQUENCER_RPM_OutBus  = rpm_out_q;
    assign WHEEL_UPDATE_SEQUENCER_RAD_OutBus  = rad_out_q;
    assign WHEEL_UPDATE_SEQUENCER_BUSY_Out    = busy_q;
    assign WHEEL_UPDATE_SEQUENCER_DONE_Out    = done_q;
    assign WHEEL_UPDATE_SEQUENCER_OVERRUN_Out = overrun_q;
    assign WHEEL_UPDATE_SEQUENCER_TIMEOUT_Out = timeout_q;

endmodule

// File: tb/tb_wheel_update_sequencer.sv
// Bench for wheel_update_sequencer: mock Q8 multiplier plus a per-wheel reference
// model of the expected operand list, committed results and DONE timing.
module tb_wheel_update_sequencer;
    localparam int unsigned NW  = 17;
    localparam int unsigned RD  = 8;
    localparam int unsigned WH  = 4;
    localparam int unsigned TO  = 64;
    localparam int unsigned OPS = 2 * WH;
    localparam logic [NW-1:0] K1 = 17'h004C5;
    localparam logic [NW-1:0] K2 = 17'h0001B;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst_n, tick, ack;
    logic [WH*RD-1:0] counts;
    logic [NW-1:0]    result, mula, mulb;
    logic             mulreq, busy, done, overrun, tmo;
    logic [WH*NW-1:0] rpm_bus, rad_bus;

    wheel_update_sequencer dut (
        .WHEEL_UPDATE_SEQUENCER_CLOCK          (clk),
        .WHEEL_UPDATE_SEQUENCER_RESET_InLow    (rst_n),
        .WHEEL_UPDATE_SEQUENCER_TICK_In        (tick),
        .WHEEL_UPDATE_SEQUENCER_COUNT_InBus    (counts),
        .WHEEL_UPDATE_SEQUENCER_MULREQ_Out     (mulreq),
        .WHEEL_UPDATE_SEQUENCER_MULA_OutBus    (mula),
        .WHEEL_UPDATE_SEQUENCER_MULB_OutBus    (mulb),
        .WHEEL_UPDATE_SEQUENCER_MULACK_In      (ack),
        .WHEEL_UPDATE_SEQUENCER_MULRESULT_InBus(result),
        .WHEEL_UPDATE_SEQUENCER_RPM_OutBus     (rpm_bus),
        .WHEEL_UPDATE_SEQUENCER_RAD_OutBus     (rad_bus),
        .WHEEL_UPDATE_SEQUENCER_BUSY_Out       (busy),
        .WHEEL_UPDATE_SEQUENCER_DONE_Out       (done),
        .WHEEL_UPDATE_SEQUENCER_OVERRUN_Out    (overrun),
        .WHEEL_UPDATE_SEQUENCER_TIMEOUT_Out    (tmo)
    );

    int compared   = 0;
    int mismatched = 0;

    // Sign-magnitude Q8 product, magnitude truncated to the word
    function automatic logic [NW-1:0] qmul(input logic [NW-1:0] a, input logic [NW-1:0] b);
        longint unsigned ma, mb, m;
        ma = a[NW-2:0];
        mb = b[NW-2:0];
        m  = (ma * mb) >> 8;
        return {a[NW-1] ^ b[NW-1], m[NW-2:0]};
    endfunction

    // Mock multiplier: ACK after mock_lat extra cycles of REQ, never for op mock_drop
    int            mock_lat = 1, mock_drop = -1, mock_op = 0, age = 0, stab_err = 0;
    bit            inject_ack = 1'b0;
    logic [NW-1:0] inject_res = '0;
    logic [NW-1:0] first_a, first_b;
    logic [NW-1:0] obs_a[$], obs_b[$];

    always @(posedge clk) begin
        #2;
        ack    = 1'b0;
        result = '0;
        if (mulreq === 1'b1) begin
            age++;
            if (age == 1) begin
                first_a = mula;
                first_b = mulb;
                obs_a.push_back(mula);
                obs_b.push_back(mulb);
                mock_op++;
            end else if (mula !== first_a || mulb !== first_b) begin
                stab_err++;
            end
            if (age == mock_lat + 1 && (mock_op - 1) != mock_drop) begin
                ack    = 1'b1;
                result = qmul(mula, mulb);
            end
        end else begin
            age = 0;
        end
        if (inject_ack) begin
            ack    = 1'b1;
            result = inject_res;
        end
    end

    // Reference model results
    logic [NW-1:0]    exp_a[OPS], exp_b[OPS];
    logic [WH*NW-1:0] exp_rpm, exp_rad;
    int               exp_done;

    task automatic build_model(input logic [WH*RD-1:0] cnts, input int lat, input int drop);
        logic [NW-1:0] a, r, d;
        exp_done = 0;
        for (int w = 0; w < int'(WH); w++) begin
            a = NW'(cnts[w*RD +: RD]) << 8;
            r = (2*w == drop) ? '0 : qmul(a, K1);
            d = (2*w + 1 == drop) ? '0 : qmul(r, K2);
            exp_a[2*w] = a;   exp_b[2*w] = K1;
            exp_a[2*w+1] = r; exp_b[2*w+1] = K2;
            exp_rpm[w*NW +: NW] = r;
            exp_rad[w*NW +: NW] = d;
        end
        for (int op = 0; op < int'(OPS); op++) begin
            exp_done += ((op == drop) ? int'(TO) : lat + 1) + 1;
        end
    endtask

    // Run observations
    int               done_cyc, done_count, gap_err, change_err, rises;
    logic [WH*NW-1:0] done_rpm, done_rad;
    logic             snap_req, snap_busy, snap_done;
    logic [WH*NW-1:0] snap_rpm, snap_rad;

    task automatic apply_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick  = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // Tick in cycle 0 (plus optional extra ticks / one-cycle reset), observe up to max_cyc cycles
    task automatic run_seq(input logic [WH*RD-1:0] cnts, input int lat, input int drop,
                           input int tick2, input int tick3, input int rst_at, input int max_cyc);
        logic [WH*NW-1:0] prev_rpm, prev_rad;
        logic prev_req, seen_high, rst_prev;
        int   low_run;
        counts = cnts; mock_lat = lat; mock_drop = drop; mock_op = 0; stab_err = 0;
        obs_a.delete(); obs_b.delete();
        done_cyc = -1; done_count = 0; gap_err = 0; change_err = 0; rises = 0;
        prev_rpm = rpm_bus; prev_rad = rad_bus; prev_req = 1'b0; seen_high = 1'b0;
        rst_prev = 1'b0; low_run = 0;
        for (int k = 0; k < max_cyc; k++) begin
            @(posedge clk); #1;
            tick  = (k == 0) || (k == tick2) || (k == tick3);
            rst_n = !(k == rst_at);
            @(negedge clk);
            if (done === 1'b1) begin
                done_count++;
                if (done_cyc < 0) done_cyc = k;
                done_rpm = rpm_bus;
                done_rad = rad_bus;
            end else if (!rst_prev && (rpm_bus !== prev_rpm || rad_bus !== prev_rad)) begin
                change_err++;
            end
            if (k == rst_at + 1) begin
                snap_req = mulreq; snap_busy = busy; snap_done = done;
                snap_rpm = rpm_bus; snap_rad = rad_bus;
            end
            rst_prev = (k == rst_at);
            prev_rpm = rpm_bus;
            prev_rad = rad_bus;
            if (mulreq === 1'b1) begin
                if (!prev_req) begin
                    if (seen_high && low_run != 1) gap_err++;
                    seen_high = 1'b1;
                    rises++;
                end
                low_run = 0;
            end else begin
                low_run++;
            end
            prev_req = mulreq;
            if (done_cyc >= 0 && k >= done_cyc + 3 && rst_at < 0) break;
        end
        tick  = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        tick  = 1'b1;
        @(negedge clk);
        compared++;
        if ({mulreq, busy, done, overrun, tmo} !== 5'b0) begin
            mismatched++;
            $display("FAIL reset_flags got=%b want=00000", {mulreq, busy, done, overrun, tmo});
        end
        compared++;
        if (mula !== '0 || mulb !== '0) begin
            mismatched++;
            $display("FAIL reset_operands got=%h/%h want=0/0", mula, mulb);
        end
        compared++;
        if (rpm_bus !== '0 || rad_bus !== '0) begin
            mismatched++;
            $display("FAIL reset_outputs got=%h/%h want=0/0", rpm_bus, rad_bus);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tick  = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || mulreq !== 1'b0) begin
            mismatched++;
            $display("FAIL reset_tick_ignored got busy=%b req=%b want=0/0", busy, mulreq);
        end
    endtask

    task automatic test_single_wheel();
        logic [WH*RD-1:0] c;
        apply_reset();
        c = 32'h0000_000A;
        build_model(c, 1, -1);
        run_seq(c, 1, -1, -1, -1, -1, 60);
        compared++;
        if (obs_a.size() < 2 || obs_a[0] !== 17'h00A00 || obs_b[0] !== 17'h004C5 ||
            obs_a[1] !== 17'h02FB2 || obs_b[1] !== 17'h0001B) begin
            mismatched++;
            $display("FAIL single_first_ops got n=%0d want op0 00a00*004c5 op1 02fb2*0001b",
                     obs_a.size());
        end
        compared++;
        if (done_cyc !== 24) begin
            mismatched++;
            $display("FAIL single_done_cycle got=%0d want=24", done_cyc);
        end
        compared++;
        if (done_rpm[NW-1:0] !== 17'h02FB2 || done_rad[NW-1:0] !== 17'h00507) begin
            mismatched++;
            $display("FAIL single_wheel0 got=%h/%h want=02fb2/00507",
                     done_rpm[NW-1:0], done_rad[NW-1:0]);
        end
        compared++;
        if (done_rpm !== exp_rpm || done_rad !== exp_rad) begin
            mismatched++;
            $display("FAIL single_buses got=%h/%h want=%h/%h", done_rpm, done_rad, exp_rpm, exp_rad);
        end
    endtask

    task automatic test_order();
        logic [WH*RD-1:0] c;
        apply_reset();
        c = {8'd128, 8'd255, 8'd1, 8'd0};
        build_model(c, 1, -1);
        run_seq(c, 1, -1, -1, -1, -1, 60);
        compared++;
        if (obs_a.size() != OPS) begin
            mismatched++;
            $display("FAIL order_op_count got=%0d want=%0d", obs_a.size(), OPS);
        end
        for (int i = 0; i < int'(OPS) && i < obs_a.size(); i++) begin
            compared++;
            if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
                mismatched++;
                $display("FAIL order_op%0d got=%h*%h want=%h*%h", i, obs_a[i], obs_b[i],
                         exp_a[i], exp_b[i]);
            end
        end
        compared++;
        if (gap_err != 0 || change_err != 0 || stab_err != 0) begin
            mismatched++;
            $display("FAIL order_protocol got gap=%0d change=%0d stab=%0d want=0/0/0",
                     gap_err, change_err, stab_err);
        end
        compared++;
        if (done_rpm !== exp_rpm || done_rad !== exp_rad || done_cyc != exp_done) begin
            mismatched++;
            $display("FAIL order_result got=%h/%h @%0d want=%h/%h @%0d", done_rpm, done_rad,
                     done_cyc, exp_rpm, exp_rad, exp_done);
        end
        compared++;
        if (overrun !== 1'b0 || tmo !== 1'b0) begin
            mismatched++;
            $display("FAIL order_flags got ovr=%b tmo=%b want=0/0", overrun, tmo);
        end
    endtask

    task automatic test_overrun();
        logic [WH*RD-1:0] c;
        apply_reset();
        c = $urandom;
        build_model(c, 1, -1);
        run_seq(c, 1, -1, 10, 24, -1, 60);
        compared++;
        if (overrun !== 1'b1) begin
            mismatched++;
            $display("FAIL overrun_flag got=%b want=1", overrun);
        end
        compared++;
        if (done_count != 1 || done_cyc != 24 || busy !== 1'b0) begin
            mismatched++;
            $display("FAIL overrun_single_done got n=%0d @%0d busy=%b want 1 @24 busy=0",
                     done_count, done_cyc, busy);
        end
        compared++;
        if (done_rpm !== exp_rpm || done_rad !== exp_rad || rises != int'(OPS)) begin
            mismatched++;
            $display("FAIL overrun_result got=%h/%h ops=%0d want=%h/%h ops=%0d", done_rpm,
                     done_rad, rises, exp_rpm, exp_rad, OPS);
        end
    endtask

    task automatic test_random();
        logic [WH*RD-1:0] c;
        int lat;
        apply_reset();
        for (int it = 0; it < 6; it++) begin
            c   = $urandom;
            lat = int'($urandom_range(0, 3));
            build_model(c, lat, -1);
            run_seq(c, lat, -1, -1, -1, -1, 80);
            compared++;
            if (obs_a.size() != OPS) begin
                mismatched++;
                $display("FAIL rand%0d_op_count got=%0d want=%0d", it, obs_a.size(), OPS);
            end
            for (int i = 0; i < int'(OPS) && i < obs_a.size(); i++) begin
                compared++;
                if (obs_a[i] !== exp_a[i] || obs_b[i] !== exp_b[i]) begin
                    mismatched++;
                    $display("FAIL rand%0d_op%0d got=%h*%h want=%h*%h", it, i, obs_a[i],
                             obs_b[i], exp_a[i], exp_b[i]);
                end
            end
            compared++;
            if (done_rpm !== exp_rpm || done_rad !== exp_rad || done_cyc != exp_done ||
                done_count != 1) begin
                mismatched++;
                $display("FAIL rand%0d_result got=%h/%h @%0d n=%0d want=%h/%h @%0d n=1", it,
                         done_rpm, done_rad, done_cyc, done_count, exp_rpm, exp_rad, exp_done);
            end
            compared++;
            if (gap_err != 0 || change_err != 0 || stab_err != 0 || tmo !== 1'b0) begin
                mismatched++;
                $display("FAIL rand%0d_protocol got gap=%0d change=%0d stab=%0d tmo=%b want 0",
                         it, gap_err, change_err, stab_err, tmo);
            end
        end
    endtask

    task automatic test_timeout();
        logic [WH*RD-1:0] c;
        apply_reset();
        c = $urandom | 32'h0000_0100;
        build_model(c, 1, 2);
        run_seq(c, 1, 2, -1, -1, -1, 200);
        compared++;
        if (tmo !== 1'b1) begin
            mismatched++;
            $display("FAIL timeout_flag got=%b want=1", tmo);
        end
        compared++;
        if (done_count != 1 || done_cyc != exp_done) begin
            mismatched++;
            $display("FAIL timeout_done got n=%0d @%0d want n=1 @%0d", done_count, done_cyc,
                     exp_done);
        end
        compared++;
        if (done_rpm !== exp_rpm || done_rad !== exp_rad) begin
            mismatched++;
            $display("FAIL timeout_result got=%h/%h want=%h/%h", done_rpm, done_rad, exp_rpm,
                     exp_rad);
        end
        compared++;
        if (obs_a.size() != OPS || obs_a[3] !== 17'h0) begin
            mismatched++;
            $display("FAIL timeout_rad_operand got n=%0d want n=%0d and op3 A=0", obs_a.size(),
                     OPS);
        end
    endtask

    task automatic test_midreset();
        logic [WH*RD-1:0] c;
        apply_reset();
        c = $urandom | 32'h0101_0101;
        run_seq(c, 1, -1, -1, -1, -1, 60);
        c = $urandom | 32'h0101_0101;
        run_seq(c, 1, -1, -1, 12, 12, 45);
        compared++;
        if (snap_req !== 1'b0 || snap_busy !== 1'b0 || snap_done !== 1'b0) begin
            mismatched++;
            $display("FAIL midreset_flags got req=%b busy=%b done=%b want 0/0/0", snap_req,
                     snap_busy, snap_done);
        end
        compared++;
        if (snap_rpm !== '0 || snap_rad !== '0) begin
            mismatched++;
            $display("FAIL midreset_outputs got=%h/%h want=0/0", snap_rpm, snap_rad);
        end
        compared++;
        if (done_count != 0) begin
            mismatched++;
            $display("FAIL midreset_no_done got=%0d want=0", done_count);
        end
        build_model(c, 1, -1);
        run_seq(c, 1, -1, -1, -1, -1, 60);
        compared++;
        if (done_rpm !== exp_rpm || done_rad !== exp_rad || done_cyc != 24) begin
            mismatched++;
            $display("FAIL midreset_fresh got=%h/%h @%0d want=%h/%h @24", done_rpm, done_rad,
                     done_cyc, exp_rpm, exp_rad);
        end
    endtask

    task automatic test_ack_edges();
        logic [WH*RD-1:0] c;
        logic [WH*NW-1:0] keep_rpm;
        apply_reset();
        c = $urandom;
        run_seq(c, 1, -1, -1, -1, -1, 60);
        keep_rpm = rpm_bus;
        @(posedge clk); #1;
        inject_res = NW'($urandom);
        inject_ack = 1'b1;
        @(posedge clk); #1;
        inject_ack = 1'b0;
        @(negedge clk);
        compared++;
        if (busy !== 1'b0 || mulreq !== 1'b0 || done !== 1'b0 || rpm_bus !== keep_rpm) begin
            mismatched++;
            $display("FAIL idle_ack_ignored got busy=%b req=%b done=%b want 0/0/0 unchanged",
                     busy, mulreq, done);
        end
        c = $urandom;
        build_model(c, 0, -1);
        run_seq(c, 0, -1, -1, -1, -1, 60);
        compared++;
        if (done_cyc != 16 || done_rpm !== exp_rpm || done_rad !== exp_rad || gap_err != 0) begin
            mismatched++;
            $display("FAIL same_cycle_ack got @%0d %h/%h gap=%0d want @16 %h/%h gap=0",
                     done_cyc, done_rpm, done_rad, gap_err, exp_rpm, exp_rad);
        end
    endtask

    initial begin
        rst_n = 1'b1; tick = 1'b0; counts = '0; ack = 1'b0; result = '0;
        test_reset();
        test_single_wheel();
        test_order();
        test_overrun();
        test_random();
        test_timeout();
        test_midreset();
        test_ack_edges();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end

endmodule
